// File: rtl/tdm_mux_8to1.sv
// tdm_mux_8to1: 8-channel to 1-lane TDM multiplexer, round-robin grant, registered source-tagged output.
// Define TDM_STRICT_SLOT_EN for fixed-slot scheduling (one slot per channel, empty slots idle the lane).
module tdm_mux_8to1 #(
   parameter int DATA_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [8*DATA_W-1:0] in_data,
   input  logic [7:0]          in_valid,
   output logic [7:0]          in_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic [2:0]          out_sel,
   output logic                out_valid,
   input  logic                out_ready
);

   logic [DATA_W-1:0] ch_data [8];
   logic [2:0]        rr_ptr;
   logic [2:0]        grant;
   logic              free;
   logic              any_req;
   logic              xfer;

   for (genvar i = 0; i < 8; i++) begin : g_ch
      assign ch_data[i] = in_data[i*DATA_W +: DATA_W];
   end

   // Output slot can take a new word when empty or when its word leaves this cycle.
   assign free = !out_valid || out_ready;

`ifdef TDM_STRICT_SLOT_EN
   // The slot counter alone decides who may talk; no search.
   assign grant   = rr_ptr;
   assign any_req = in_valid[rr_ptr];
`else
   assign any_req = |in_valid;

   always_comb begin
      logic [2:0] idx;
      logic       found;
      grant = rr_ptr;
      idx   = rr_ptr;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         idx = rr_ptr + 3'(k);
         if (!found && in_valid[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end
`endif

   assign xfer     = free && any_req;
   assign in_ready = xfer ? (8'b1 << grant) : 8'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= 3'd0;
         rr_ptr    <= 3'd0;
      end else begin
         if (xfer) begin
            out_data  <= ch_data[grant];
            out_sel   <= grant;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
`ifdef TDM_STRICT_SLOT_EN
         if (free) rr_ptr <= rr_ptr + 3'd1;
`else
         if (xfer) rr_ptr <= grant + 3'd1;
`endif
      end
   end

endmodule

// File: tb/tb_tdm_mux_8to1.sv
// tb_tdm_mux_8to1: directed vector table plus hand sequences for reset and strict-slot corners.
module tb_tdm_mux_8to1;
   localparam int DATA_W = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic [8*DATA_W-1:0] in_data;
   logic [7:0]          in_valid;
   logic [7:0]          in_ready;
   logic [DATA_W-1:0]   out_data;
   logic [2:0]          out_sel;
   logic                out_valid;
   logic                out_ready;

   int checks = 0;
   int errors = 0;

   // Fixed per-channel words: ch7..ch0
   localparam logic [63:0] DMAP = {8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'hA5, 8'h11, 8'h01};

   typedef struct {
      logic [7:0] iv;
      logic       ordy;
      logic [7:0] rdy;
      logic       ov;
      logic [2:0] sel;
      logic [7:0] dat;
   } vec_t;

   always #5 clk = ~clk;

   tdm_mux_8to1 #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

`ifndef TDM_STRICT_SLOT_EN
   vec_t tv [29];
`endif

   initial begin
      in_data   = DMAP;
      in_valid  = 8'h00;
      out_ready = 1'b1;
      rst       = 1'b1;
      #12;
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_out_sel", out_sel, 3'd0);
      chk("reset_out_data", out_data, 8'h00);
      chk("reset_in_ready", in_ready, 8'h00);
      @(negedge clk);
      rst = 1'b0;

      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         chk("idle_out_valid", out_valid, 1'b0);
         chk("idle_in_ready", in_ready, 8'h00);
         chk("idle_out_sel", out_sel, 3'd0);
      end

`ifndef TDM_STRICT_SLOT_EN
      //            iv     ordy  rdy    ov    sel   data
      tv[0]  = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00};
      tv[1]  = '{8'h04, 1'b1, 8'h04, 1'b1, 3'd2, 8'hA5};
      tv[2]  = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd2, 8'hA5};
      tv[3]  = '{8'h80, 1'b1, 8'h80, 1'b1, 3'd7, 8'h77};
      tv[4]  = '{8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 8'h01};
      tv[5]  = '{8'hFF, 1'b1, 8'h02, 1'b1, 3'd1, 8'h11};
      tv[6]  = '{8'hFF, 1'b1, 8'h04, 1'b1, 3'd2, 8'hA5};
      tv[7]  = '{8'hFF, 1'b1, 8'h08, 1'b1, 3'd3, 8'h33};
      tv[8]  = '{8'hFF, 1'b1, 8'h10, 1'b1, 3'd4, 8'h44};
      tv[9]  = '{8'hFF, 1'b1, 8'h20, 1'b1, 3'd5, 8'h55};
      tv[10] = '{8'hFF, 1'b1, 8'h40, 1'b1, 3'd6, 8'h66};
      tv[11] = '{8'hFF, 1'b1, 8'h80, 1'b1, 3'd7, 8'h77};
      tv[12] = '{8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 8'h01};
      tv[13] = '{8'h40, 1'b1, 8'h40, 1'b1, 3'd6, 8'h66};
      tv[14] = '{8'h81, 1'b1, 8'h80, 1'b1, 3'd7, 8'h77};
      tv[15] = '{8'h01, 1'b1, 8'h01, 1'b1, 3'd0, 8'h01};
      tv[16] = '{8'h22, 1'b0, 8'h00, 1'b1, 3'd0, 8'h01};
      tv[17] = '{8'h22, 1'b0, 8'h00, 1'b1, 3'd0, 8'h01};
      tv[18] = '{8'h22, 1'b0, 8'h00, 1'b1, 3'd0, 8'h01};
      tv[19] = '{8'h22, 1'b0, 8'h00, 1'b1, 3'd0, 8'h01};
      tv[20] = '{8'h22, 1'b0, 8'h00, 1'b1, 3'd0, 8'h01};
      tv[21] = '{8'h22, 1'b1, 8'h02, 1'b1, 3'd1, 8'h11};
      tv[22] = '{8'h20, 1'b1, 8'h20, 1'b1, 3'd5, 8'h55};
      tv[23] = '{8'h00, 1'b0, 8'h00, 1'b1, 3'd5, 8'h55};
      tv[24] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd5, 8'h55};
      tv[25] = '{8'h08, 1'b0, 8'h08, 1'b1, 3'd3, 8'h33};
      tv[26] = '{8'h10, 1'b0, 8'h00, 1'b1, 3'd3, 8'h33};
      tv[27] = '{8'h10, 1'b1, 8'h10, 1'b1, 3'd4, 8'h44};
      tv[28] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd4, 8'h44};

      for (int v = 0; v < 29; v++) begin
         @(negedge clk);
         in_valid  = tv[v].iv;
         out_ready = tv[v].ordy;
         #1;
         chk($sformatf("v%0d_in_ready", v), in_ready, tv[v].rdy);
         @(posedge clk); #1;
         chk($sformatf("v%0d_out_valid", v), out_valid, tv[v].ov);
         chk($sformatf("v%0d_out_sel", v), out_sel, tv[v].sel);
         chk($sformatf("v%0d_out_data", v), out_data, tv[v].dat);
      end
`else
      // Strict slots: only channel 5 requesting; slot counter starts at 0 after reset.
      @(negedge clk);
      rst = 1'b1;
      #1;
      @(negedge clk);
      rst       = 1'b0;
      in_valid  = 8'h20;
      out_ready = 1'b1;
      for (int n = 0; n < 24; n++) begin
         #1;
         chk($sformatf("slot%0d_in_ready", n), in_ready, (n % 8 == 5) ? 8'h20 : 8'h00);
         @(posedge clk); #1;
         chk($sformatf("slot%0d_out_valid", n), out_valid, (n % 8 == 5) ? 1'b1 : 1'b0);
         chk($sformatf("slot%0d_out_sel", n), out_sel, (n >= 5) ? 3'd5 : 3'd0);
         chk($sformatf("slot%0d_out_data", n), out_data, (n >= 5) ? 8'h55 : 8'h00);
         @(negedge clk);
      end
`endif

      // Reset mid-stream: pending word dropped at once, pointer back to channel 0.
      @(negedge clk);
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("mid_pre_out_valid", out_valid, 1'b1);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_out_sel", out_sel, 3'd0);
      chk("mid_rst_out_data", out_data, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 8'h01);
      @(posedge clk); #1;
      chk("post_rst_out_sel", out_sel, 3'd0);
      chk("post_rst_out_data", out_data, 8'h01);
      chk("post_rst_out_valid", out_valid, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
